// File: rtl/uart_tx_buffered_pkg.sv
// Shared definitions for the buffered UART transmitter: parity modes,
// shifter state encodings and the parity helper.
package uart_tx_buffered_pkg;

    localparam int UART_PARITY_NONE = 0;
    localparam int UART_PARITY_EVEN = 1;
    localparam int UART_PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        UART_S_IDLE   = 3'd0,
        UART_S_START  = 3'd1,
        UART_S_DATA   = 3'd2,
        UART_S_PARITY = 3'd3,
        UART_S_STOP   = 3'd4
    } uart_state_e;

    // Parity of a word zero-extended to 8 bits; upper zeros do not change the XOR.
    function automatic logic parity_of(input logic [7:0] data, input int mode);
        parity_of = (mode == UART_PARITY_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_tx_buffered_sync_fifo.sv
// Synchronous first-word-fall-through FIFO. rd_data shows the head word
// whenever empty is low. Writes when full and reads when empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage array: contents need no reset, validity is tracked by count.
    always_ff @(posedge clock) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO in front of a start/data/parity/stop
// shifter with its own bit timer. The line output is registered.
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int CLKS_PER_BIT = 208,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int DEPTH        = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [DATA_BITS-1:0]       in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       uart_tx,
    output logic                       uart_busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic [2:0]                 fsm_state
);

    localparam int            TW         = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    DATA_LAST  = 3'(DATA_BITS - 1);
    localparam logic [2:0]    STOP_LAST  = 3'(STOP_BITS - 1);
    localparam bit            HAS_PARITY = (PARITY != UART_PARITY_NONE);

    uart_state_e          state_q, state_n;
    logic [TW-1:0]        timer_q, timer_n;
    logic [2:0]           bit_q, bit_n;
    logic [DATA_BITS-1:0] shift_q, shift_n;
    logic                 par_q, par_n;
    logic                 tx_q, tx_n;
    logic                 tick;
    logic                 push;
    logic                 pop;
    logic [DATA_BITS-1:0] fifo_rd_data;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [7:0]           rd_ext;

    // Handshake: a word transfers on a rising edge where in_valid && in_ready;
    // in_ready depends only on FIFO fullness and reset, never on in_valid.
    assign in_ready  = !fifo_full && !reset;
    assign push      = in_valid && in_ready;
    assign tick      = (timer_q == TICK_LAST);
    assign uart_tx   = tx_q;
    assign uart_busy = (state_q != UART_S_IDLE) || !fifo_empty;
    assign fsm_state = state_q;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (push),
        .wr_data (in_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Zero-extend the head word so the parity helper sees a fixed width.
    always_comb begin
        rd_ext                  = '0;
        rd_ext[DATA_BITS-1:0]   = fifo_rd_data;
    end

    // Next-state logic; the line level is derived from the next state so
    // the registered output changes exactly on bit boundaries.
    always_comb begin
        state_n = state_q;
        timer_n = timer_q + 1'b1;
        bit_n   = bit_q;
        shift_n = shift_q;
        par_n   = par_q;
        pop     = 1'b0;
        tx_n    = 1'b1;

        unique case (state_q)
            UART_S_IDLE: begin
                timer_n = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_n = UART_S_START;
                end
            end
            UART_S_START: begin
                if (tick) begin
                    timer_n = '0;
                    bit_n   = '0;
                    state_n = UART_S_DATA;
                end
            end
            UART_S_DATA: begin
                if (tick) begin
                    timer_n = '0;
                    if (bit_q == DATA_LAST) begin
                        bit_n   = '0;
                        state_n = HAS_PARITY ? UART_S_PARITY : UART_S_STOP;
                    end else begin
                        bit_n   = bit_q + 1'b1;
                        shift_n = shift_q >> 1;
                    end
                end
            end
            UART_S_PARITY: begin
                if (tick) begin
                    timer_n = '0;
                    bit_n   = '0;
                    state_n = UART_S_STOP;
                end
            end
            UART_S_STOP: begin
                if (tick) begin
                    timer_n = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_n = '0;
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            state_n = UART_S_START;
                        end else begin
                            state_n = UART_S_IDLE;
                        end
                    end else begin
                        bit_n = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                timer_n = '0;
                state_n = UART_S_IDLE;
            end
        endcase

        if (pop) begin
            shift_n = fifo_rd_data;
            par_n   = parity_of(rd_ext, PARITY);
        end

        case (state_n)
            UART_S_START:  tx_n = 1'b0;
            UART_S_DATA:   tx_n = shift_n[0];
            UART_S_PARITY: tx_n = par_n;
            default:       tx_n = 1'b1;
        endcase
    end

    // Shifter registers; reset aborts any frame and drives the line idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= UART_S_IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_n;
            timer_q <= timer_n;
            bit_q   <= bit_n;
            shift_q <= shift_n;
            par_q   <= par_n;
            tx_q    <= tx_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: one 8N1 instance with a frame monitor and
// scoreboard, plus three small instances for parity and stop-bit variants.
module tb_uart_tx_buffered;

    localparam int CPB = 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;

    // main 8N1 instance
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_tx;
    logic       m_busy;
    logic [4:0] m_count;
    logic [2:0] m_state;

    // variant instances: 0 = 8E1, 1 = 8O1, 2 = 7E2
    logic [7:0] a_data;
    logic [2:0] a_valid;
    logic [2:0] a_ready;
    logic [2:0] a_tx;
    logic [2:0] a_busy;
    logic [2:0] a_count0, a_count1, a_count2;
    logic [2:0] a_state0, a_state1, a_state2;

    logic [7:0]  exp_q[$];
    int          start_q[$];
    logic [15:0] aux_exp_q[$];
    int          aux_len_q[$];

    uart_tx_buffered #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DEPTH(16)) u_main (
        .clock(clock), .reset(reset), .in_data(m_data), .in_valid(m_valid), .in_ready(m_ready),
        .uart_tx(m_tx), .uart_busy(m_busy), .fifo_count(m_count), .fsm_state(m_state));

    uart_tx_buffered #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .DEPTH(4)) u_even (
        .clock(clock), .reset(reset), .in_data(a_data), .in_valid(a_valid[0]), .in_ready(a_ready[0]),
        .uart_tx(a_tx[0]), .uart_busy(a_busy[0]), .fifo_count(a_count0), .fsm_state(a_state0));

    uart_tx_buffered #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .DEPTH(4)) u_odd (
        .clock(clock), .reset(reset), .in_data(a_data), .in_valid(a_valid[1]), .in_ready(a_ready[1]),
        .uart_tx(a_tx[1]), .uart_busy(a_busy[1]), .fifo_count(a_count1), .fsm_state(a_state1));

    uart_tx_buffered #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .DEPTH(4)) u_seven (
        .clock(clock), .reset(reset), .in_data(a_data[6:0]), .in_valid(a_valid[2]), .in_ready(a_ready[2]),
        .uart_tx(a_tx[2]), .uart_busy(a_busy[2]), .fifo_count(a_count2), .fsm_state(a_state2));

    always @(posedge clock) cyc++;

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [15:0] make_frame(input logic [7:0] d, input int nd, input int par);
        logic [15:0] f;
        logic        p;
        f    = '1;
        f[0] = 1'b0;
        p    = 1'b0;
        for (int i = 0; i < nd; i++) begin
            f[1+i] = d[i];
            p      = p ^ d[i];
        end
        if (par == 1) f[1+nd] = p;
        else if (par == 2) f[1+nd] = ~p;
        return f;
    endfunction

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (m_busy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        repeat (2) tick();
        vectors++;
        if (m_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s idle_timeout: busy=%b after %0d cycles, required 0", name, m_busy, n);
        end
    endtask

    // ---------------- frame monitor for the 8N1 instance ----------------
    initial begin : monitor
        logic [7:0] got;
        logic [7:0] want;
        logic       have_exp;
        logic       line_bad;
        logic       aborted;
        logic       lvl;
        forever begin
            @(negedge clock);
            if (!reset && m_tx === 1'b0) begin
                start_q.push_back(cyc);
                have_exp = (exp_q.size() != 0);
                want     = have_exp ? exp_q.pop_front() : 8'h00;
                got      = '0;
                line_bad = 1'b0;
                aborted  = 1'b0;
                for (int c = 0; c < 40; c++) begin
                    if (c > 0) @(negedge clock);
                    if (reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (c < 4) lvl = 1'b0;
                    else if (c < 36) lvl = want[(c-4)/4];
                    else lvl = 1'b1;
                    if (m_tx !== lvl) line_bad = 1'b1;
                    if (c >= 4 && c < 36 && (c % 4) == 2) got[(c-4)/4] = m_tx;
                end
                if (!aborted) begin
                    vectors++;
                    if (!have_exp) begin
                        miscompares++;
                        $display("FAIL frame_unexpected: got data 0x%02h, required no frame", got);
                    end else if (line_bad || got !== want) begin
                        miscompares++;
                        $display("FAIL frame: got 0x%02h (line_bad=%b), required 0x%02h with exact bit timing",
                                 got, line_bad, want);
                    end
                end
            end
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (m_ready !== 1'b0 || m_tx !== 1'b1 || m_busy !== 1'b0 || m_count !== 5'd0) begin
                miscompares++;
                $display("FAIL reset_state: ready=%b tx=%b busy=%b count=%0d, required 0 1 0 0",
                         m_ready, m_tx, m_busy, m_count);
            end
        end
        vectors++;
        if (a_tx !== 3'b111 || a_busy !== 3'b000 || a_ready !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_variants: tx=%b busy=%b ready=%b, required 111 000 000", a_tx, a_busy, a_ready);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (m_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready: got %b, required 1", m_ready);
        end
    endtask

    task automatic test_single_8n1();
        m_data  = 8'h61;
        m_valid = 1'b1;
        tick();
        exp_q.push_back(8'h61);
        m_valid = 1'b0;
        vectors++;
        if (m_tx !== 1'b1 || m_busy !== 1'b1 || m_count !== 5'd1) begin
            miscompares++;
            $display("FAIL single_after_push: tx=%b busy=%b count=%0d, required 1 1 1", m_tx, m_busy, m_count);
        end
        tick();
        vectors++;
        if (m_tx !== 1'b0 || m_count !== 5'd0) begin
            miscompares++;
            $display("FAIL single_start_latency: tx=%b count=%0d, required 0 0", m_tx, m_count);
        end
        repeat (39) tick();
        vectors++;
        if (m_busy !== 1'b1 || m_tx !== 1'b1) begin
            miscompares++;
            $display("FAIL single_last_stop_cycle: busy=%b tx=%b, required 1 1", m_busy, m_tx);
        end
        tick();
        vectors++;
        if (m_busy !== 1'b0 || m_tx !== 1'b1) begin
            miscompares++;
            $display("FAIL single_busy_fall: busy=%b tx=%b, required 0 1", m_busy, m_tx);
        end
        wait_idle(100, "single");
    endtask

    task automatic test_parity();
        int          nd[3];
        int          par[3];
        int          ns[3];
        logic [7:0]  word;
        logic [15:0] f, got, mask;
        int          nbits, len, tail, exp_tail, waited;
        nd  = '{8, 8, 7};
        par = '{1, 2, 1};
        ns  = '{1, 1, 2};
        for (int k = 0; k < 3; k++) begin
            word  = (k == 2) ? 8'h41 : 8'h61;
            nbits = 1 + nd[k] + 1 + ns[k];
            aux_exp_q.push_back(make_frame(word, nd[k], par[k]));
            aux_len_q.push_back(nbits);
            a_data     = word;
            a_valid[k] = 1'b1;
            tick();
            a_valid    = 3'b000;
            waited     = 0;
            do begin
                tick();
                waited++;
            end while (a_tx[k] !== 1'b0 && waited < 10);
            f     = aux_exp_q.pop_front();
            nbits = aux_len_q.pop_front();
            got   = '0;
            len   = -1;
            tail  = 0;
            for (int c = 0; c < 80; c++) begin
                if (a_busy[k] !== 1'b1) begin
                    len = c;
                    break;
                end
                if (a_tx[k] === 1'b1) tail++;
                else tail = 0;
                if ((c % 4) == 2 && (c / 4) < 16) got[c/4] = a_tx[k];
                tick();
            end
            exp_tail = 0;
            for (int b = nbits - 1; b >= 0; b--) begin
                if (f[b] !== 1'b1) break;
                exp_tail += CPB;
            end
            mask = (16'd1 << nbits) - 16'd1;
            vectors++;
            if ((got & mask) !== (f & mask)) begin
                miscompares++;
                $display("FAIL parity_bits[%0d]: line 0x%04h, required 0x%04h (bit0 = start)", k, got & mask, f & mask);
            end
            vectors++;
            if (len != nbits * CPB) begin
                miscompares++;
                $display("FAIL parity_len[%0d]: %0d cycles, required %0d", k, len, nbits * CPB);
            end
            vectors++;
            if (tail != exp_tail) begin
                miscompares++;
                $display("FAIL parity_tail_high[%0d]: %0d cycles, required %0d", k, tail, exp_tail);
            end
        end
    endtask

    task automatic test_back_to_back();
        start_q.delete();
        m_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            m_data = 8'($urandom_range(0, 255));
            vectors++;
            if (m_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL fill_ready[%0d]: got %b, required 1", i, m_ready);
            end
            tick();
            exp_q.push_back(m_data);
        end
        vectors++;
        if (m_count !== 5'd16 || m_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_full: count=%0d ready=%b, required 16 0", m_count, m_ready);
        end
        m_data = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (m_count !== 5'd16 || m_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL fill_refused[%0d]: count=%0d ready=%b, required 16 0", i, m_count, m_ready);
            end
        end
        m_valid = 1'b0;
        wait_idle(1200, "back_to_back");
        vectors++;
        if (start_q.size() != 17) begin
            miscompares++;
            $display("FAIL b2b_frame_count: %0d frames, required 17", start_q.size());
        end else begin
            int bad;
            bad = 0;
            for (int i = 1; i < 17; i++) if (start_q[i] - start_q[i-1] != 40) bad++;
            vectors++;
            if (bad != 0) begin
                miscompares++;
                $display("FAIL b2b_gap: %0d frame spacings differ, required all 40 cycles", bad);
            end
        end
    endtask

    task automatic test_simul_push_pop();
        m_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m_data = 8'($urandom_range(0, 255));
            tick();
            exp_q.push_back(m_data);
        end
        m_valid = 1'b0;
        vectors++;
        if (m_count !== 5'd3) begin
            miscompares++;
            $display("FAIL simul_preload: count=%0d, required 3", m_count);
        end
        repeat (37) tick();
        vectors++;
        if (m_count !== 5'd3 || m_tx !== 1'b1) begin
            miscompares++;
            $display("FAIL simul_last_stop: count=%0d tx=%b, required 3 1", m_count, m_tx);
        end
        m_data  = 8'h5C;
        m_valid = 1'b1;
        tick();
        exp_q.push_back(8'h5C);
        m_valid = 1'b0;
        vectors++;
        if (m_count !== 5'd3 || m_tx !== 1'b0) begin
            miscompares++;
            $display("FAIL simul_push_pop: count=%0d tx=%b, required 3 0", m_count, m_tx);
        end
        wait_idle(400, "simul");
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        m_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            m_data = 8'($urandom_range(0, 255));
            tick();
            exp_q.push_back(m_data);
        end
        m_valid = 1'b0;
        vectors++;
        if (m_count !== 5'd5) begin
            miscompares++;
            $display("FAIL midrst_queued: count=%0d, required 5", m_count);
        end
        repeat (12) tick();
        reset = 1'b1;
        exp_q.delete();
        tick();
        vectors++;
        if (m_tx !== 1'b1 || m_count !== 5'd0 || m_ready !== 1'b0 || m_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_abort: tx=%b count=%0d ready=%b busy=%b, required 1 0 0 0",
                     m_tx, m_count, m_ready, m_busy);
        end
        tick();
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (m_tx !== 1'b1 || m_busy !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL midrst_quiet: %0d cycles active after release, required 0", bad);
        end
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        m_valid = 1'b0;
        m_data  = '0;
        a_valid = 3'b000;
        a_data  = '0;
        test_reset();
        test_single_8n1();
        test_parity();
        test_back_to_back();
        test_simul_push_pop();
        test_reset_mid_frame();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d words never seen, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
